// File: rtl/stage_branch_pkg.sv
// stage_branch_pkg: shared widths, branch decode constants and the commit qualifier
package stage_branch_pkg;
    localparam int DEF_WL_W  = 16;
    localparam int DEF_STG_W = 3;
    localparam logic [3:0] BR_DEC_00 = 4'b0001;
    localparam logic [3:0] BR_DEC_01 = 4'b0010;
    localparam logic [3:0] BR_DEC_10 = 4'b0100;
    localparam logic [3:0] BR_DEC_11 = 4'b1000;
    function automatic logic commit(input logic ct_n);
        return ~ct_n;
    endfunction
endpackage

// File: rtl/stage_branch_branch_reg.sv
// branch_reg: BR1/BR2 flops loaded from sign, overflow and zero tests of the write bus
module branch_reg
    import stage_branch_pkg::*;
#(
    parameter int WL_W = DEF_WL_W
) (
    input  logic            clock,
    input  logic            clr,
    input  logic            ce,
    input  logic [WL_W-1:0] wl,
    input  logic            tsgn,
    input  logic            tov,
    input  logic            tmz,
    input  logic            tpzg,
    output logic            br1,
    output logic            br2,
    output logic [3:0]      br_dec
);
    logic br1_nxt;
    logic br2_nxt;
    // next-state selection: BR1 both writers load the sign; BR2 writers ranked tov > tmz > tpzg
    always_comb begin
        br1_nxt = (tsgn || tov) ? wl[WL_W-1] : br1;
        br2_nxt = tov ? (wl[WL_W-1] ^ wl[WL_W-2]) : tmz ? (&wl) : tpzg ? ~(|wl) : br2;
    end
    // branch registers, cleared on restart, loaded only inside the CT window
    always_ff @(posedge clock) begin
        if (clr) begin
            br1 <= 1'b0;
            br2 <= 1'b0;
        end else if (ce) begin
            br1 <= br1_nxt;
            br2 <= br2_nxt;
        end
    end
    // one-hot decode of {br1,br2} for the crosspoint decoder
    always_comb begin
        br_dec = br1 ? (br2 ? BR_DEC_11 : BR_DEC_10) : (br2 ? BR_DEC_01 : BR_DEC_00);
    end
endmodule

// File: rtl/stage_branch.sv
// stage_branch: stage and branch registers stepping in lockstep with the CT/T12 timing
module stage_branch
    import stage_branch_pkg::*;
#(
    parameter int WL_W  = DEF_WL_W,
    parameter int STG_W = DEF_STG_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             gojam,
    input  logic             ct_n,
    input  logic             t12_n,
    input  logic             nisq,
    input  logic [STG_W-1:0] st_set,
    input  logic [WL_W-1:0]  wl,
    input  logic             tsgn,
    input  logic             tov,
    input  logic             tmz,
    input  logic             tpzg,
    output logic [STG_W-1:0] stg,
    output logic [STG_W-1:0] stg_n,
    output logic [STG_W-1:0] stg_pend,
    output logic             br1,
    output logic             br1_n,
    output logic             br2,
    output logic             br2_n,
    output logic [3:0]       br_dec
);
    logic clr;
    logic ce;
    assign clr = rst || gojam;
    assign ce  = commit(ct_n);
    // stage bits accumulate during the cycle and commit at T12; nisq starts a fresh instruction
    always_ff @(posedge clock) begin
        if (clr) begin
            stg      <= '0;
            stg_pend <= '0;
        end else if (ce) begin
            if (t12_n) begin
                stg_pend <= stg_pend | st_set;
            end else begin
                stg      <= nisq ? '0 : (stg_pend | st_set);
                stg_pend <= '0;
            end
        end
    end
    branch_reg #(.WL_W(WL_W)) u_branch (
        .clock  (clock),
        .clr    (clr),
        .ce     (ce),
        .wl     (wl),
        .tsgn   (tsgn),
        .tov    (tov),
        .tmz    (tmz),
        .tpzg   (tpzg),
        .br1    (br1),
        .br2    (br2),
        .br_dec (br_dec)
    );
    // complemented views for the active-low decoder inputs
    always_comb begin
        stg_n = ~stg;
        br1_n = ~br1;
        br2_n = ~br2;
    end
endmodule

// File: tb/tb_stage_branch.sv
// tb_stage_branch: directed vector table plus reset/gojam sequences for stage_branch
module tb_stage_branch;
    logic        clock = 1'b0;
    logic        rst, gojam, ct_n, t12_n, nisq, tsgn, tov, tmz, tpzg;
    logic [2:0]  st_set;
    logic [15:0] wl;
    logic [2:0]  stg, stg_n, stg_pend;
    logic        br1, br1_n, br2, br2_n;
    logic [3:0]  br_dec;
    int checks = 0;
    int failures = 0;

    stage_branch dut (
        .clock(clock), .rst(rst), .gojam(gojam), .ct_n(ct_n), .t12_n(t12_n),
        .nisq(nisq), .st_set(st_set), .wl(wl), .tsgn(tsgn), .tov(tov),
        .tmz(tmz), .tpzg(tpzg), .stg(stg), .stg_n(stg_n), .stg_pend(stg_pend),
        .br1(br1), .br1_n(br1_n), .br2(br2), .br2_n(br2_n), .br_dec(br_dec)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        gojam, ct_n, t12_n, nisq, tsgn, tov, tmz, tpzg;
        logic [2:0]  st_set;
        logic [15:0] wl;
        logic [2:0]  e_stg, e_pend;
        logic        e_br1, e_br2;
        logic [3:0]  e_dec;
    } vec_t;

    localparam int N = 22;
    vec_t v [N];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] es, input logic [2:0] ep,
                             input logic eb1, input logic eb2, input logic [3:0] ed);
        chk("stg", idx, {13'd0, stg}, {13'd0, es});
        chk("stg_n", idx, {13'd0, stg_n}, {13'd0, ~es});
        chk("stg_pend", idx, {13'd0, stg_pend}, {13'd0, ep});
        chk("br1", idx, {15'd0, br1}, {15'd0, eb1});
        chk("br1_n", idx, {15'd0, br1_n}, {15'd0, ~eb1});
        chk("br2", idx, {15'd0, br2}, {15'd0, eb2});
        chk("br2_n", idx, {15'd0, br2_n}, {15'd0, ~eb2});
        chk("br_dec", idx, {12'd0, br_dec}, {12'd0, ed});
    endtask

    task automatic idle();
        gojam = 0; ct_n = 1; t12_n = 1; nisq = 0; st_set = 0; wl = 0;
        tsgn = 0; tov = 0; tmz = 0; tpzg = 0;
    endtask

    initial begin
        //        gj ct t12 nq sg ov mz pz  st     wl        stg    pend  b1 b2 dec
        v[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 3'b001, 16'h0000, 3'b000, 3'b001, 0, 0, 4'b0001};
        v[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 16'h0000, 3'b011, 3'b000, 0, 0, 4'b0001};
        v[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 3'b100, 16'h0000, 3'b011, 3'b100, 0, 0, 4'b0001};
        v[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 3'b100, 16'h0000, 3'b000, 3'b000, 0, 0, 4'b0001};
        v[4]  = '{0, 1, 1, 0, 0, 0, 0, 0, 3'b001, 16'h0000, 3'b000, 3'b000, 0, 0, 4'b0001};
        v[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 16'h0000, 3'b000, 3'b000, 0, 0, 4'b0001};
        v[6]  = '{0, 0, 1, 0, 0, 0, 0, 0, 3'b111, 16'h0000, 3'b000, 3'b111, 0, 0, 4'b0001};
        v[7]  = '{0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b000, 3'b111, 0, 0, 4'b0001};
        v[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 16'h0000, 3'b111, 3'b000, 0, 0, 4'b0001};
        v[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 16'h4000, 3'b111, 3'b000, 0, 1, 4'b0010};
        v[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 16'h8000, 3'b111, 3'b000, 1, 1, 4'b1000};
        v[11] = '{0, 1, 1, 0, 0, 1, 0, 0, 3'b000, 16'h4000, 3'b111, 3'b000, 1, 1, 4'b1000};
        v[12] = '{0, 0, 1, 0, 0, 0, 1, 1, 3'b000, 16'hFFFF, 3'b111, 3'b000, 1, 1, 4'b1000};
        v[13] = '{0, 0, 1, 0, 0, 0, 1, 1, 3'b000, 16'h0000, 3'b111, 3'b000, 1, 0, 4'b0100};
        v[14] = '{0, 0, 1, 0, 0, 0, 0, 1, 3'b000, 16'h0000, 3'b111, 3'b000, 1, 1, 4'b1000};
        v[15] = '{0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 16'hC000, 3'b111, 3'b000, 1, 0, 4'b0100};
        v[16] = '{0, 0, 1, 0, 0, 1, 1, 0, 3'b000, 16'h4000, 3'b111, 3'b000, 0, 1, 4'b0010};
        v[17] = '{0, 0, 1, 0, 0, 0, 0, 1, 3'b000, 16'h0001, 3'b111, 3'b000, 0, 0, 4'b0001};
        v[18] = '{0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 16'h7FFF, 3'b111, 3'b000, 0, 0, 4'b0001};
        v[19] = '{0, 0, 1, 0, 0, 1, 0, 0, 3'b010, 16'h8000, 3'b111, 3'b010, 1, 1, 4'b1000};
        v[20] = '{1, 0, 0, 0, 1, 1, 1, 1, 3'b111, 16'hC000, 3'b000, 3'b000, 0, 0, 4'b0001};
        v[21] = '{0, 0, 1, 0, 0, 0, 1, 0, 3'b000, 16'hFFFF, 3'b000, 3'b000, 0, 1, 4'b0010};

        idle();
        rst = 1;
        repeat (3) @(posedge clock);
        #1 check_all(100, 3'b000, 3'b000, 0, 0, 4'b0001);
        @(negedge clock) rst = 0;
        @(posedge clock) #1 check_all(101, 3'b000, 3'b000, 0, 0, 4'b0001);

        for (int i = 0; i < N; i++) begin
            @(negedge clock);
            gojam = v[i].gojam; ct_n = v[i].ct_n; t12_n = v[i].t12_n; nisq = v[i].nisq;
            tsgn = v[i].tsgn; tov = v[i].tov; tmz = v[i].tmz; tpzg = v[i].tpzg;
            st_set = v[i].st_set; wl = v[i].wl;
            @(posedge clock) #1 check_all(i, v[i].e_stg, v[i].e_pend, v[i].e_br1, v[i].e_br2, v[i].e_dec);
        end

        @(negedge clock) idle(); ct_n = 0; st_set = 3'b111;
        @(negedge clock) t12_n = 0;
        @(negedge clock) t12_n = 1; st_set = 3'b101; wl = 16'h8000; tsgn = 1; tmz = 1;
        @(negedge clock) idle(); wl = 16'hFFFF; tmz = 1; ct_n = 0;
        @(posedge clock) #1 check_all(200, 3'b111, 3'b101, 1, 1, 4'b1000);
        @(negedge clock) idle(); gojam = 1;
        @(posedge clock) #1 check_all(201, 3'b000, 3'b000, 0, 0, 4'b0001);
        @(negedge clock) idle(); st_set = 3'b001;
        repeat (3) @(posedge clock);
        #1 check_all(202, 3'b000, 3'b000, 0, 0, 4'b0001);

        @(negedge clock) idle(); ct_n = 0; st_set = 3'b110; wl = 16'h8000; tsgn = 1; rst = 1; gojam = 1;
        @(posedge clock) #1 check_all(203, 3'b000, 3'b000, 0, 0, 4'b0001);
        @(negedge clock) rst = 0; idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
